// File: rtl/rabbit_link_pkg.sv
// Shared definitions for the Rabbit->FPGA profile link.
// Holds the frame geometry (word width, header width, largest legal frame),
// the writer FSM state encoding and the header bit-order helpers. The
// reader-side bench imports this package as well, so both ends agree on the
// frame layout.
package rabbit_link_pkg;

    localparam int WORD_BITS = 184;   // bits per profile word
    localparam int CNT_BITS  = 5;     // width of word-count header / word_total
    localparam int MAX_WORDS = 12;    // largest legal word_total
    localparam int BIT_CNT_W = 8;     // width of the per-word bit counter

    // Header goes out most significant bit first.
    localparam bit HDR_MSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_GAP    = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SHIFT  = 3'd4,
        ST_DONE   = 3'd5
    } link_state_e;

    // Returns the header in transmit order: bit [CNT_BITS-1] leaves first.
    function automatic logic [CNT_BITS-1:0] header_bits(input logic [CNT_BITS-1:0] total);
        logic [CNT_BITS-1:0] rev;
        for (int i = 0; i < CNT_BITS; i++) begin
            rev[i] = total[CNT_BITS-1-i];
        end
        return HDR_MSB_FIRST ? total : rev;
    endfunction

    // A frame must carry between one and MAX_WORDS words.
    function automatic logic total_ok(input logic [CNT_BITS-1:0] total);
        return (total != {CNT_BITS{1'b0}}) && (int'(total) <= MAX_WORDS);
    endfunction

endpackage

// File: rtl/rabbit_serial_writer_sclk_bit_timer.sv
// sclk_bit_timer: bit-time generator for the serial writer.
// While enable is high it produces a square SCLK level (CLK_DIV cycles low,
// CLK_DIV cycles high, starting low), a set_data strobe in the first cycle of
// each low half and a bit_end strobe in the last high cycle (the falling edge
// happens at the following clock edge). Dropping enable parks SCLK low with
// the divider cleared, so the next enabled cycle starts a fresh bit.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous reset, active low
//   enable   in   run the divider
//   sclk     out  SCLK level (internal, not yet retimed)
//   set_data out  strobe: drive the next data bit now
//   bit_end  out  strobe: last cycle of the bit
module sclk_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic sclk,
    output logic set_data,
    output logic bit_end
);

    localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1'b1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             sclk_r;

    // Half-period divider; SCLK toggles each time a half period completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r <= DIV_ZERO;
            sclk_r    <= 1'b0;
        end else if (!enable) begin
            div_cnt_r <= DIV_ZERO;
            sclk_r    <= 1'b0;
        end else if (div_cnt_r == HALF_LAST) begin
            div_cnt_r <= DIV_ZERO;
            sclk_r    <= ~sclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
            sclk_r    <= sclk_r;
        end
    end

    // Phase strobes decoded from the divider position.
    always_comb begin
        set_data = enable && !sclk_r && (div_cnt_r == DIV_ZERO);
        bit_end  = enable &&  sclk_r && (div_cnt_r == HALF_LAST);
    end

    assign sclk = sclk_r;

endmodule

// File: rtl/rabbit_serial_writer.sv
// rabbit_serial_writer: transmit end of the Rabbit->FPGA profile link.
// Sends a frame = CNT_BITS-bit word-count header (MSB first), then
// word_total profile words of WORD_BITS bits each (index 0 first), on an
// SCLK/SDIO pair. Every header/word is followed by GAP_CYCLES of idle
// (SCLK and SDIO low). Words are pulled with a valid/ready handshake; a
// missing word stalls the link with SCLK low indefinitely.
// All outputs are registered. SCLK_out is retimed by one cycle against the
// internal bit timer so that SDIO_out and SCLK_out both update at the start
// of the low half: data is then stable CLK_DIV cycles either side of the
// rising edge the reader samples on.
// Ports:
//   ten_MHz_ext in   system clock
//   key_2_reset in   synchronous reset, active low
//   start       in   begin a frame (only looked at in IDLE)
//   word_total  in   number of words, captured with an accepted start
//   word_in     in   next profile word, [0] sent first
//   word_valid  in   word_in valid
//   word_ready  out  writer takes word_in this cycle
//   SCLK_out    out  serial clock
//   SDIO_out    out  serial data
//   busy        out  frame in progress
//   done        out  one-cycle pulse at frame completion
//   err         out  one-cycle pulse: start rejected for a bad word_total
module rabbit_serial_writer
    import rabbit_link_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                 ten_MHz_ext,
    input  logic                 key_2_reset,
    input  logic                 start,
    input  logic [CNT_BITS-1:0]  word_total,
    input  logic [0:WORD_BITS-1] word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
    output logic                 SCLK_out,
    output logic                 SDIO_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int                   GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]     GAP_ZERO  = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0]     GAP_ONE   = GAP_W'(1'b1);
    localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ZERO  = {BIT_CNT_W{1'b0}};
    localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1'b1);
    localparam logic [BIT_CNT_W-1:0] HDR_LAST  = BIT_CNT_W'(CNT_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] WORD_LAST = BIT_CNT_W'(WORD_BITS - 1);
    localparam logic [CNT_BITS-1:0]  CNT_ZERO  = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0]  CNT_ONE   = CNT_BITS'(1'b1);

    link_state_e          state_r;
    link_state_e          state_s;
    logic [CNT_BITS-1:0]  total_r;
    logic [CNT_BITS-1:0]  word_cnt_r;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic [GAP_W-1:0]     gap_cnt_r;
    logic [0:WORD_BITS-1] shreg_r;

    logic                 sclk_out_r;
    logic                 sdio_out_r;
    logic                 word_ready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;

    logic                 start_ok_s;
    logic                 start_bad_s;
    logic                 load_s;
    logic                 bit_last_s;
    logic                 tmr_en_s;
    logic                 tmr_sclk_s;
    logic                 set_data_s;
    logic                 bit_end_s;

    sclk_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk      (ten_MHz_ext),
        .rst_n    (key_2_reset),
        .enable   (tmr_en_s),
        .sclk     (tmr_sclk_s),
        .set_data (set_data_s),
        .bit_end  (bit_end_s)
    );

    // Next-state and control decode for the frame sequencer.
    always_comb begin
        state_s     = state_r;
        start_ok_s  = 1'b0;
        start_bad_s = 1'b0;
        load_s      = 1'b0;
        tmr_en_s    = (state_r == ST_HEADER) || (state_r == ST_SHIFT);
        // Header and word phases end on different bit indices.
        if (state_r == ST_HEADER) begin
            bit_last_s = (bit_cnt_r == HDR_LAST);
        end else begin
            bit_last_s = (bit_cnt_r == WORD_LAST);
        end
        case (state_r)
            ST_IDLE: begin
                if (start && total_ok(word_total)) begin
                    start_ok_s = 1'b1;
                    state_s    = ST_HEADER;
                end else if (start) begin
                    start_bad_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HEADER, ST_SHIFT: begin
                if (bit_end_s && bit_last_s) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = state_r;
                end
            end
            ST_GAP: begin
                if ((gap_cnt_r == GAP_LAST) && (word_cnt_r == total_r)) begin
                    state_s = ST_DONE;
                end else if (gap_cnt_r == GAP_LAST) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_LOAD: begin
                if (word_valid && word_ready_r) begin
                    load_s  = 1'b1;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge ten_MHz_ext) begin
        if (!key_2_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shift register: header is preloaded at start, words at the handshake;
    // index 0 always holds the bit being sent.
    always_ff @(posedge ten_MHz_ext) begin
        if (!key_2_reset) begin
            shreg_r <= {WORD_BITS{1'b0}};
        end else if (start_ok_s) begin
            shreg_r <= {header_bits(word_total), {(WORD_BITS-CNT_BITS){1'b0}}};
        end else if (load_s) begin
            shreg_r <= word_in;
        end else if (bit_end_s) begin
            shreg_r <= {shreg_r[1:WORD_BITS-1], 1'b0};
        end else begin
            shreg_r <= shreg_r;
        end
    end

    // Bit counter: restarts for the header, for every word and after each phase.
    always_ff @(posedge ten_MHz_ext) begin
        if (!key_2_reset) begin
            bit_cnt_r <= BIT_ZERO;
        end else if (start_ok_s || load_s) begin
            bit_cnt_r <= BIT_ZERO;
        end else if (bit_end_s && bit_last_s) begin
            bit_cnt_r <= BIT_ZERO;
        end else if (bit_end_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Frame bookkeeping: latched total and words completed so far.
    always_ff @(posedge ten_MHz_ext) begin
        if (!key_2_reset) begin
            total_r    <= CNT_ZERO;
            word_cnt_r <= CNT_ZERO;
        end else if (start_ok_s) begin
            total_r    <= word_total;
            word_cnt_r <= CNT_ZERO;
        end else if ((state_r == ST_SHIFT) && bit_end_s && bit_last_s) begin
            total_r    <= total_r;
            word_cnt_r <= word_cnt_r + CNT_ONE;
        end else begin
            total_r    <= total_r;
            word_cnt_r <= word_cnt_r;
        end
    end

    // Idle-gap length counter.
    always_ff @(posedge ten_MHz_ext) begin
        if (!key_2_reset) begin
            gap_cnt_r <= GAP_ZERO;
        end else if ((state_r == ST_GAP) && (gap_cnt_r != GAP_LAST)) begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
        end else begin
            gap_cnt_r <= GAP_ZERO;
        end
    end

    // Registered link and status outputs.
    always_ff @(posedge ten_MHz_ext) begin
        if (!key_2_reset) begin
            sclk_out_r   <= 1'b0;
            sdio_out_r   <= 1'b0;
            word_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            sclk_out_r <= tmr_sclk_s;
            // SDIO follows the timer's low-half strobe and is forced low
            // whenever no bit is on the wire.
            if (set_data_s) begin
                sdio_out_r <= shreg_r[0];
            end else if (!tmr_en_s) begin
                sdio_out_r <= 1'b0;
            end else begin
                sdio_out_r <= sdio_out_r;
            end
            word_ready_r <= (state_s == ST_LOAD);
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= (state_s == ST_DONE);
            err_r        <= start_bad_s;
        end
    end

    assign word_ready = word_ready_r;
    assign SCLK_out   = sclk_out_r;
    assign SDIO_out   = sdio_out_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_rabbit_serial_writer.sv
// Directed bench for rabbit_serial_writer. Expected serial bits are queued
// when the header/word is handed to the writer and popped on every rising
// SCLK edge seen at the outputs.
module tb_rabbit_serial_writer;
    import rabbit_link_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 16;

    logic                 clk;
    logic                 key_2_reset;
    logic                 start;
    logic [CNT_BITS-1:0]  word_total;
    logic [0:WORD_BITS-1] word_in;
    logic                 word_valid;
    logic                 word_ready;
    logic                 SCLK_out;
    logic                 SDIO_out;
    logic                 busy;
    logic                 done;
    logic                 err;

    int   n_pass   = 0;
    int   n_total  = 0;
    int   cyc      = 0;
    int   rise_cnt = 0;
    int   hi_len   = 0;
    logic mon_en   = 1'b0;
    logic sclk_q   = 1'b0;
    logic sdio_q   = 1'b0;
    logic mon_e;
    logic exp_q[$];

    rabbit_serial_writer #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP)
    ) dut (
        .ten_MHz_ext (clk),
        .key_2_reset (key_2_reset),
        .start       (start),
        .word_total  (word_total),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .SCLK_out    (SCLK_out),
        .SDIO_out    (SDIO_out),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Serial monitor on the falling clock edge.
    always @(negedge clk) begin
        if (!mon_en) begin
            hi_len = 0;
        end else begin
            if (SCLK_out && !sclk_q) begin
                rise_cnt++;
                mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                chk("sdio_bit", {31'd0, SDIO_out}, {31'd0, mon_e});
            end
            if (SCLK_out) begin
                hi_len++;
            end else if (sclk_q) begin
                chk("sclk_high_len", hi_len, CLK_DIV);
                hi_len = 0;
            end
            if (SDIO_out !== sdio_q) chk("sdio_change_sclk_low", {31'd0, SCLK_out}, 32'd0);
        end
        sclk_q = SCLK_out;
        sdio_q = SDIO_out;
    end

    function automatic logic [0:WORD_BITS-1] make_word(input int kind, input int k);
        logic [0:WORD_BITS-1] w;
        w = {WORD_BITS{1'b0}};
        case (kind)
            0: w[0] = 1'b1;
            1: for (int b = 0; b < WORD_BITS / 8; b++) w[b*8 +: 8] = 8'(k);
            default: for (int i = 0; i < WORD_BITS; i++) w[i] = 1'($urandom_range(0, 1));
        endcase
        return w;
    endfunction

    // Runs one frame of n words. stall_word: word index held back 500 cycles
    // (-1 none); rst_word: reset 90 bits into this word (-1 none); poke: pulse
    // start with a bad total while busy.
    task automatic do_frame(input int n, input int kind, input int stall_word,
                            input int rst_word, input bit poke);
        logic [0:WORD_BITS-1] w;
        logic [CNT_BITS-1:0]  t;
        int k, c0, r0, stall_add, lat_exp;
        logic seen_done;
        k = 0;
        stall_add = 0;
        t = CNT_BITS'(n);
        for (int i = 0; i < CNT_BITS; i++) exp_q.push_back(t[CNT_BITS-1-i]);
        word_total = t;
        start = 1'b1;
        w = make_word(kind, 0);
        word_in = w;
        word_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c0 = cyc;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (poke) begin
            start = 1'b1;
            word_total = 5'd0;
            @(posedge clk); #1;
            start = 1'b0;
            word_total = t;
            chk("no_err_start_while_busy", {31'd0, err}, 32'd0);
            chk("busy_kept", {31'd0, busy}, 32'd1);
        end
        while (!done && (cyc - c0) < 25000) begin
            if (word_ready && word_valid && k == stall_word && stall_add == 0) begin
                word_valid = 1'b0;
                repeat (500) @(posedge clk);
                #1;
                stall_add = 500;
                chk("stall_sclk_low", {31'd0, SCLK_out}, 32'd0);
                chk("stall_ready_held", {31'd0, word_ready}, 32'd1);
                word_valid = 1'b1;
            end else if (word_ready && word_valid) begin
                for (int i = 0; i < WORD_BITS; i++) exp_q.push_back(w[i]);
                k++;
                @(posedge clk); #1;
                w = make_word(kind, k);
                word_in = w;
                if (rst_word == k - 1) begin
                    r0 = rise_cnt;
                    while (rise_cnt < r0 + 90 && (cyc - c0) < 25000) begin
                        @(posedge clk); #1;
                    end
                    mon_en = 1'b0;
                    key_2_reset = 1'b0;
                    @(posedge clk); #1;
                    key_2_reset = 1'b1;
                    word_valid = 1'b0;
                    chk("midrst_sclk", {31'd0, SCLK_out}, 32'd0);
                    chk("midrst_sdio", {31'd0, SDIO_out}, 32'd0);
                    chk("midrst_busy", {31'd0, busy}, 32'd0);
                    chk("midrst_ready", {31'd0, word_ready}, 32'd0);
                    chk("midrst_done_err", {30'd0, done, err}, 32'd0);
                    exp_q.delete();
                    seen_done = 1'b0;
                    repeat (40) begin
                        @(posedge clk); #1;
                        seen_done = seen_done | done | busy;
                    end
                    chk("no_done_after_reset", {31'd0, seen_done}, 32'd0);
                    mon_en = 1'b1;
                    return;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        // One LOAD cycle per word when the word is already valid.
        lat_exp = (CNT_BITS + n * WORD_BITS) * 2 * CLK_DIV + (n + 1) * GAP + n + stall_add;
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("frame_len", cyc - c0, lat_exp);
        chk("words_taken", k, n);
        chk("bits_all_sent", exp_q.size(), 32'd0);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        word_valid = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse_end", {31'd0, done}, 32'd0);
        chk("busy_drop", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        key_2_reset = 1'b0;
        start       = 1'b0;
        word_total  = 5'd0;
        word_in     = {WORD_BITS{1'b0}};
        word_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", {31'd0, SCLK_out}, 32'd0);
        chk("rst_sdio", {31'd0, SDIO_out}, 32'd0);
        chk("rst_ready", {31'd0, word_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        key_2_reset = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Rejected totals: 0 and MAX_WORDS+1.
        for (int j = 0; j < 2; j++) begin
            start = 1'b1;
            word_total = (j == 0) ? 5'd0 : 5'd13;
            @(posedge clk); #1;
            start = 1'b0;
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_busy_low", {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            chk("err_one_cycle", {31'd0, err}, 32'd0);
            chk("err_sclk_low", {31'd0, SCLK_out}, 32'd0);
        end

        do_frame(1, 0, -1, -1, 1'b0);    // single word, only index 0 set
        do_frame(12, 1, -1, -1, 1'b0);   // full frame, byte pattern k
        do_frame(2, 2, 1, -1, 1'b0);     // stall before word 1
        do_frame(5, 2, -1, 3, 1'b0);     // reset 90 bits into word 3
        do_frame(2, 2, -1, -1, 1'b1);    // recovery frame, start poked while busy

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
